regfile_sb: RTL and testbench

Parametrised ARM register file with three combinational read ports, one posedge write-back port, same-cycle write-to-read bypass, and a per-register pending-write scoreboard that raises a hazard flag for the decode stage. It sits between ID and WB. It replaces the fixed 15×32, two-read, negedge-write register file. Register indices at or above `NUM_REGS` are reserved for the PC, which lives outside this block.

---
 rtl/arm_pkg.sv | 8 +
 rtl/sb_counter.sv | 23 ++
 rtl/regfile_sb.sv | 95 +++++++++
 tb/tb_regfile_sb.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM core constants: datapath width, register index width,
// the default architectural register count and the PC index.
package arm_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 15;
    localparam int PC_IDX   = 15;
endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: saturating up/down, never wraps.
module sb_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count
);

    // inc and dec together cancel; each alone moves one step, clamped at the ends
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !dec && count != '1) begin
            count <= count + PEND_W'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - PEND_W'(1);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file: three combinational read ports with
// write-back bypass, one posedge write port, and a pending-write
// scoreboard that tells decode when a source is still in flight.
module regfile_sb #(
    parameter int DATA_W   = arm_pkg::DATA_W,
    parameter int NUM_REGS = arm_pkg::NUM_REGS,
    parameter int ADDR_W   = arm_pkg::ADDR_W,
    parameter int PEND_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic [ADDR_W-1:0] src3,
    input  logic [2:0]        srcValid,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic [DATA_W-1:0] reg3,
    input  logic              writeBackEn,
    input  logic [ADDR_W-1:0] destWB,
    input  logic [DATA_W-1:0] resultWB,
    input  logic              issueEn,
    input  logic [ADDR_W-1:0] issueDest,
    output logic              hazard,
    output logic              issueFull
);
    import arm_pkg::*;

    logic [DATA_W-1:0]            regs [NUM_REGS];
    logic [PEND_W-1:0]            pend [NUM_REGS];
    logic [NUM_REGS-1:0]          inc;
    logic [NUM_REGS-1:0]          dec;
    logic [2:0][ADDR_W-1:0]       src;
    logic [2:0][DATA_W-1:0]       rdata;
    logic [2:0][PEND_W-1:0]       src_pend;
    logic [2:0]                   src_in;

    assign src  = {src3, src2, src1};
    assign reg1 = rdata[0];
    assign reg2 = rdata[1];
    assign reg3 = rdata[2];

    // Data array: indices at or beyond NUM_REGS (PC space) never match, so those writes drop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (writeBackEn) begin
            for (int r = 0; r < NUM_REGS; r++)
                if (destWB == ADDR_W'(r)) regs[r] <= resultWB;
        end
    end

    // One scoreboard counter per architectural register
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_sb
        assign inc[g] = issueEn && (issueDest == ADDR_W'(g)) && !issueFull;
        assign dec[g] = writeBackEn && (destWB == ADDR_W'(g)) && (pend[g] != '0);
        sb_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc[g]),
            .dec   (dec[g]),
            .count (pend[g])
        );
    end

    // Issue must stall when the destination's counter is saturated
    always_comb begin
        issueFull = 1'b0;
        for (int r = 0; r < NUM_REGS; r++)
            if (issueDest == ADDR_W'(r) && pend[r] == '1) issueFull = 1'b1;
    end

    // Read muxes with bypass, plus the decode hazard; a last write-back
    // landing this cycle clears the hazard because the bypass supplies the data
    always_comb begin
        hazard   = 1'b0;
        rdata    = '0;
        src_pend = '0;
        src_in   = '0;
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (src[i] == ADDR_W'(r)) begin
                    rdata[i]    = regs[r];
                    src_pend[i] = pend[r];
                    src_in[i]   = 1'b1;
                end
            end
            if (src_in[i] && writeBackEn && destWB == src[i]) rdata[i] = resultWB;
            if (srcValid[i] && src_in[i] && src_pend[i] != '0 &&
                !(writeBackEn && destWB == src[i] && src_pend[i] == PEND_W'(1)))
                hazard = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a vector table walked one cycle per row,
// then hand-written reset sequences.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src1, src2, src3;
    logic [2:0]  srcValid;
    logic [31:0] reg1, reg2, reg3;
    logic        writeBackEn;
    logic [3:0]  destWB;
    logic [31:0] resultWB;
    logic        issueEn;
    logic [3:0]  issueDest;
    logic        hazard, issueFull;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .src1(src1), .src2(src2), .src3(src3), .srcValid(srcValid),
        .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .writeBackEn(writeBackEn), .destWB(destWB), .resultWB(resultWB),
        .issueEn(issueEn), .issueDest(issueDest),
        .hazard(hazard), .issueFull(issueFull)
    );

    typedef struct {
        logic [3:0]  s1, s2, s3;
        logic [2:0]  sv;
        logic        wen;
        logic [3:0]  wd;
        logic [31:0] wdata;
        logic        ien;
        logic [3:0]  idst;
        logic [31:0] e1, e2, e3;
        logic        ehz, efull;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] s1, logic [3:0] s2, logic [3:0] s3, logic [2:0] sv,
                                logic wen, logic [3:0] wd, logic [31:0] wdata,
                                logic ien, logic [3:0] idst,
                                logic [31:0] e1, logic [31:0] e2, logic [31:0] e3,
                                logic ehz, logic efull);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.s3 = s3; v.sv = sv;
        v.wen = wen; v.wd = wd; v.wdata = wdata;
        v.ien = ien; v.idst = idst;
        v.e1 = e1; v.e2 = e2; v.e3 = e3; v.ehz = ehz; v.efull = efull;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        src1 = v.s1; src2 = v.s2; src3 = v.s3; srcValid = v.sv;
        writeBackEn = v.wen; destWB = v.wd; resultWB = v.wdata;
        issueEn = v.ien; issueDest = v.idst;
    endtask

    task automatic idle();
        src1 = 0; src2 = 0; src3 = 0; srcValid = 0;
        writeBackEn = 0; destWB = 0; resultWB = 0;
        issueEn = 0; issueDest = 0;
    endtask

    initial begin
        // s1 s2 s3 sv  wen wd wdata        ien idst  e1  e2  e3  hz full
        vecs.push_back(mk(0, 0, 0, 3'b000, 0, 0, 32'h0,        0, 0,  32'h0, 32'h0, 32'h0, 0, 0));
        // bypass of r5 on port 2, PC index on port 3 reads 0
        vecs.push_back(mk(0, 5, 15, 3'b000, 1, 5, 32'h12345678, 0, 0, 32'h0, 32'h12345678, 32'h0, 0, 0));
        vecs.push_back(mk(5, 0, 15, 3'b000, 0, 0, 32'h0,       0, 0,  32'h12345678, 32'h0, 32'h0, 0, 0));
        // write to index 15 is dropped and not bypassed
        vecs.push_back(mk(5, 15, 0, 3'b000, 1, 15, 32'hFFFFFFFF, 0, 0, 32'h12345678, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(5, 0, 14, 3'b000, 0, 0, 32'h0,       0, 0,  32'h12345678, 32'h0, 32'h0, 0, 0));
        // issue r7 three times, fourth attempt while full
        vecs.push_back(mk(7, 0, 0, 3'b001, 0, 0, 32'h0, 1, 7, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(7, 0, 0, 3'b001, 0, 0, 32'h0, 1, 7, 32'h0, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(7, 0, 0, 3'b001, 0, 0, 32'h0, 1, 7, 32'h0, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(7, 0, 0, 3'b001, 0, 0, 32'h0, 1, 7, 32'h0, 32'h0, 32'h0, 1, 1));
        // three write-backs: hazard 1,1,0
        vecs.push_back(mk(7, 0, 0, 3'b001, 1, 7, 32'hA1, 0, 7, 32'hA1, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk(7, 0, 0, 3'b001, 1, 7, 32'hA2, 0, 7, 32'hA2, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(7, 0, 0, 3'b001, 1, 7, 32'hA3, 0, 7, 32'hA3, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(7, 0, 0, 3'b001, 0, 0, 32'h0,  0, 7, 32'hA3, 32'h0, 32'h0, 0, 0));
        // simultaneous issue and write-back on r2 with one pending
        vecs.push_back(mk(2, 0, 0, 3'b001, 0, 0, 32'h0,  1, 2, 32'h0,  32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 3'b001, 1, 2, 32'hB2, 1, 2, 32'hB2, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 3'b001, 0, 0, 32'h0,  0, 2, 32'hB2, 32'h0, 32'h0, 1, 0));
        // srcValid masking with r2, r4, r9 pending
        vecs.push_back(mk(2, 0, 0, 3'b000, 0, 0, 32'h0, 1, 4, 32'hB2, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(2, 4, 2, 3'b000, 0, 0, 32'h0, 1, 9, 32'hB2, 32'h0, 32'hB2, 0, 0));
        vecs.push_back(mk(2, 4, 9, 3'b010, 0, 0, 32'h0, 0, 0, 32'hB2, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(2, 4, 9, 3'b100, 0, 0, 32'h0, 0, 0, 32'hB2, 32'h0, 32'h0, 1, 0));
        vecs.push_back(mk(2, 4, 9, 3'b000, 0, 0, 32'h0, 0, 0, 32'hB2, 32'h0, 32'h0, 0, 0));
        // issue to PC index is ignored and never reports full
        vecs.push_back(mk(15, 0, 0, 3'b001, 0, 0, 32'h0, 1, 15, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mk(15, 2, 0, 3'b001, 0, 0, 32'h0, 0, 15, 32'h0, 32'hB2, 32'h0, 0, 0));

        // power-on reset
        idle();
        rst = 1'b0;
        #3;
        check("por.reg1", reg1, 32'h0);
        check("por.hazard", {31'h0, hazard}, 32'h0);
        check("por.issueFull", {31'h0, issueFull}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check($sformatf("v%0d.reg1", i), reg1, vecs[i].e1);
            check($sformatf("v%0d.reg2", i), reg2, vecs[i].e2);
            check($sformatf("v%0d.reg3", i), reg3, vecs[i].e3);
            check($sformatf("v%0d.hazard", i), {31'h0, hazard}, {31'h0, vecs[i].ehz});
            check($sformatf("v%0d.issueFull", i), {31'h0, issueFull}, {31'h0, vecs[i].efull});
        end

        // mid-run asynchronous reset: r3 written, r2/r4/r9 still pending
        @(negedge clk);
        idle();
        writeBackEn = 1; destWB = 3; resultWB = 32'hDEADBEEF;
        @(negedge clk);
        idle();
        src1 = 3; src2 = 2; srcValid = 3'b010;
        #1;
        check("pre_rst.reg1", reg1, 32'hDEADBEEF);
        check("pre_rst.hazard", {31'h0, hazard}, 32'h1);
        #1 rst = 1'b0;
        #1;
        check("async_rst.reg1", reg1, 32'h0);
        check("async_rst.hazard", {31'h0, hazard}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("post_rst.reg1", reg1, 32'h0);
        check("post_rst.hazard", {31'h0, hazard}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
